dsp_mac_ctrl: RTL and testbench
===============================

# dsp_mac_ctrl

Upstream sequencer for one DSP48A1 slice in multiply-accumulate use. It accepts operand pairs over a valid/ready stream and drives the slice's A, B and OPMODE inputs so that every TAPS consecutive products are summed into P. It waits out the slice pipeline, captures the finished sum and presents it on a one-deep valid/ready output buffer. The slice is instantiated with OPMODEREG=1, A1REG=B1REG=MREG=PREG=1, A0REG=B0REG=0 and B_INPUT="DIRECT", and its clock enables are tied high.

## Interface
Parameters:
- WIDTH_2, 18: operand width, matching the slice A/B width.
- WIDTH_4, 48: slice P width.
- OUT_W, 32: result width; legal range 1..WIDTH_4.
- TAPS, 8: products per result; legal range 1..1024.
- PIPE_LAT, 3: cycles from an A/B slot being driven to P holding its sum; minimum 1.
- MODE_LAG, 1: cycles by which a slot's OPMODE trails its A/B on the slice ports; legal range 0..PIPE_LAT-1.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  operand pair accepted when high together with in_valid.
- in_a  in  WIDTH_2  multiplicand.
- in_b  in  WIDTH_2  multiplier.
- dsp_A  out  WIDTH_2  to slice A; registered.
- dsp_B  out  WIDTH_2  to slice B; registered.
- dsp_OPMODE  out  8  to slice OPMODE; registered and delayed by MODE_LAG.
- dsp_P  in  WIDTH_4  from slice P.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed when high together with out_valid.
- out_data  out  OUT_W  result.
- out_sat  out  1  result was saturated (see Configuration).

## Operation
- FSM has two states.
  - ACCUM: in_ready=1.
  - DRAIN: in_ready=0.
- Slot: each clock the block drives one A/B slot plus that slot's OPMODE code. The code reaches dsp_OPMODE MODE_LAG cycles after the slot's A/B.
- ACCUM, handshake (in_valid & in_ready):
  - Register dsp_A=in_a and dsp_B=in_b.
  - Slot code is 8'h01 (X=M, Z=0) when tap_cnt==0, else 8'h09 (X=M, Z=P).
  - tap_cnt increments.
- ACCUM, no handshake (bubble):
  - dsp_A=dsp_B=0.
  - Slot code is 8'h09 when tap_cnt!=0, else 8'h00.
  - tap_cnt is unchanged.
- Leaving ACCUM: the handshake that brings tap_cnt to TAPS sets tap_cnt=0, clears drain_cnt and moves to DRAIN.
- DRAIN:
  - dsp_A=dsp_B=0 and slot code 8'h08 (X=0, Z=P), so P holds its value.
  - drain_cnt counts up to PIPE_LAT and saturates there.
- Capture: when drain_cnt==PIPE_LAT and (out_valid==0 or out_ready==1):
  - Load out_data and out_sat from dsp_P and set out_valid=1.
  - Return to ACCUM.
  - If out_valid stays high and out_ready stays low, DRAIN holds indefinitely.
- out_valid clears on an out_ready handshake unless a capture happens in the same cycle.
- Arithmetic: operands and sums are unsigned, as in the slice. Without the macro, out_data = dsp_P[OUT_W-1:0].
- All OPMODE codes keep bits 4 to 7 at 0: no pre-adder, add only, CIN=0.

## Timing
- Reset values:
  - in_ready=1 (FSM enters ACCUM).
  - dsp_A=0, dsp_B=0, dsp_OPMODE=8'h00, and the whole OPMODE delay line is 8'h00.
  - out_valid=0, out_data=0, out_sat=0.
  - tap_cnt=0, drain_cnt=0.
- in_ready depends on state only and never combinationally on in_valid.
- Latency:
  - From the last-tap handshake (edge e) to the capture edge is PIPE_LAT+1 edges when out_valid==0.
  - out_valid is high after edge e+PIPE_LAT+1.
- Throughput: one result per TAPS+PIPE_LAT+1 cycles without bubbles.
- A result and the next accumulation never overlap. The first tap of the next result is accepted the cycle after capture.
- Capture and an out_ready handshake in the same cycle: the new result replaces the old one and out_valid stays 1.
- RST asserted mid-accumulation or mid-drain:
  - Partial sums are discarded and counters clear.
  - The OPMODE line resets to 8'h00.
  - The slice must be reset by the same RST.
- TAPS=1: every accepted pair goes straight to DRAIN.

## Configuration
- DSP_MAC_SAT_EN defined:
  - If dsp_P[WIDTH_4-1:OUT_W] != 0, out_data is all ones and out_sat=1.
  - Otherwise out_data is the truncated value and out_sat=0.
  - When OUT_W==WIDTH_4, out_sat is always 0.
- DSP_MAC_SAT_EN undefined: out_data is truncated and out_sat is tied to 0.

## Test plan
- Basic sum: TAPS=4, pairs (1,2),(3,4),(5,6),(7,8) back-to-back, out_ready=1 -> out_data=100 with out_valid high 4 cycles after the 4th handshake; then in_ready=1.
- Bubbles: the same pairs with in_valid low for 2 cycles between each pair -> out_data=100; the dsp_OPMODE trace shows 8'h01 once, and 8'h09 on every later slot, bubbles included.
- Back-to-back results: two sets, (1,1)x4 then (2,3)x4 -> 4 then 24; the second sum does not include the first (slot code 8'h01 restarts it).
- Backpressure: out_ready=0 while 2 results are offered -> the first is held stable and the FSM stays in DRAIN with in_ready=0; out_ready=1 -> results 4 and 24 appear in order with none lost.
- Reset mid-op: assert RST after 2 of 4 taps -> all outputs read their reset values immediately; a fresh set (1,2)x4 gives 8.
- Saturation (macro defined, OUT_W=16, TAPS=2): pairs (0x3FFFF,0x3FFFF)x2 -> out_data=0xFFFF, out_sat=1. With the macro undefined -> out_data = low 16 bits of the 48-bit sum, out_sat=0.

Source files
------------

// File: rtl/dsp_mac_ctrl.sv
// dsp_mac_ctrl: operand sequencer for a DSP48A1 slice used as a multiply-accumulator.
// Sums every TAPS products into the slice P register, waits out the slice pipeline,
// then holds the finished sum in a one-deep valid/ready output buffer.
// Optional feature: define DSP_MAC_SAT_EN to saturate out_data to all ones (with out_sat)
// when the slice sum does not fit in OUT_W bits; otherwise the sum is truncated.
module dsp_mac_ctrl #(
    parameter int WIDTH_2  = 18,
    parameter int WIDTH_4  = 48,
    parameter int OUT_W    = 32,
    parameter int TAPS     = 8,
    parameter int PIPE_LAT = 3,
    parameter int MODE_LAG = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH_2-1:0] in_a,
    input  logic [WIDTH_2-1:0] in_b,
    output logic [WIDTH_2-1:0] dsp_A,
    output logic [WIDTH_2-1:0] dsp_B,
    output logic [7:0]         dsp_OPMODE,
    input  logic [WIDTH_4-1:0] dsp_P,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_sat
);

    localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int DW = $clog2(PIPE_LAT + 1);

    // OPMODE codes: X=M/Z=0 starts a sum, X=M/Z=P accumulates, X=0/Z=P holds P.
    localparam logic [7:0] OP_IDLE  = 8'h00;
    localparam logic [7:0] OP_FIRST = 8'h01;
    localparam logic [7:0] OP_ACC   = 8'h09;
    localparam logic [7:0] OP_HOLD  = 8'h08;

    typedef enum logic {ACCUM, DRAIN} state_t;

    state_t              state, state_nx;
    logic [TW-1:0]       tap_cnt, tap_nx;
    logic [DW-1:0]       drain_cnt;
    logic [WIDTH_2-1:0]  slot_a, slot_b;
    logic [7:0]          slot_code;
    logic                capture;
    logic [OUT_W-1:0]    cap_data;
    logic                cap_sat;
    logic [7:0]          mode_line [0:MODE_LAG];

    assign in_ready   = (state == ACCUM);
    assign capture    = (state == DRAIN) && (drain_cnt == DW'(PIPE_LAT)) && (!out_valid || out_ready);
    assign dsp_OPMODE = mode_line[MODE_LAG];

    // Next state and the A/B/OPMODE content of this cycle's slot.
    always_comb begin
        state_nx  = state;
        tap_nx    = tap_cnt;
        slot_a    = '0;
        slot_b    = '0;
        slot_code = OP_IDLE;
        case (state)
            ACCUM: begin
                if (in_valid) begin
                    slot_a    = in_a;
                    slot_b    = in_b;
                    slot_code = (tap_cnt == '0) ? OP_FIRST : OP_ACC;
                    if (tap_cnt == TW'(TAPS - 1)) begin
                        tap_nx   = '0;
                        state_nx = DRAIN;
                    end else begin
                        tap_nx = tap_cnt + TW'(1);
                    end
                end else begin
                    // A zero bubble still has to keep P accumulating once a sum has started.
                    slot_code = (tap_cnt != '0) ? OP_ACC : OP_IDLE;
                end
            end
            DRAIN: begin
                slot_code = OP_HOLD;
                if (capture) state_nx = ACCUM;
            end
            default: state_nx = ACCUM;
        endcase
    end

    // State and counters; drain_cnt restarts at 0 every time DRAIN is entered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ACCUM;
            tap_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            state   <= state_nx;
            tap_cnt <= tap_nx;
            if (state != DRAIN)
                drain_cnt <= '0;
            else if (drain_cnt != DW'(PIPE_LAT))
                drain_cnt <= drain_cnt + DW'(1);
        end
    end

    // Slot registers: A/B go out directly, OPMODE trails them by MODE_LAG cycles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dsp_A <= '0;
            dsp_B <= '0;
            for (int i = 0; i <= MODE_LAG; i++) mode_line[i] <= OP_IDLE;
        end else begin
            dsp_A        <= slot_a;
            dsp_B        <= slot_b;
            mode_line[0] <= slot_code;
            for (int i = 1; i <= MODE_LAG; i++) mode_line[i] <= mode_line[i-1];
        end
    end

`ifdef DSP_MAC_SAT_EN
    generate
        if (OUT_W < WIDTH_4) begin : g_sat
            assign cap_sat  = |dsp_P[WIDTH_4-1:OUT_W];
            assign cap_data = cap_sat ? {OUT_W{1'b1}} : dsp_P[OUT_W-1:0];
        end else begin : g_nosat
            assign cap_sat  = 1'b0;
            assign cap_data = dsp_P[OUT_W-1:0];
        end
    endgenerate
`else
    assign cap_sat  = 1'b0;
    assign cap_data = dsp_P[OUT_W-1:0];
`endif

    // Upper P bits are only inspected when saturation is built in.
    logic unused_p;
    assign unused_p = ^dsp_P;

    // One-deep output buffer; a capture wins over a same-cycle consume.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_data  <= cap_data;
            out_sat   <= cap_sat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dsp_mac_ctrl.sv
// tb_dsp_mac_ctrl: directed bench for dsp_mac_ctrl with a behavioural DSP48A1 MAC slice
// (A1/B1, M, P and OPMODE registers) closing the loop on dsp_P.
module tb_dsp_mac_ctrl;

    localparam int W2 = 18;
    localparam int W4 = 48;
    localparam int OW = 32;
    localparam int TP = 4;
    localparam int PL = 3;
    localparam int ML = 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W2-1:0] in_a = '0;
    logic [W2-1:0] in_b = '0;
    logic [W2-1:0] dsp_A, dsp_B;
    logic [7:0]    dsp_OPMODE;
    logic [W4-1:0] dsp_P;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] out_data;
    logic          out_sat;

    int n_chk  = 0;
    int n_pass = 0;

    dsp_mac_ctrl #(
        .WIDTH_2(W2), .WIDTH_4(W4), .OUT_W(OW), .TAPS(TP), .PIPE_LAT(PL), .MODE_LAG(ML)
    ) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .dsp_A(dsp_A), .dsp_B(dsp_B), .dsp_OPMODE(dsp_OPMODE), .dsp_P(dsp_P),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    always #5 CLK = ~CLK;

    // Slice model: A1/B1 -> M -> P, OPMODE registered once.
    logic [W2-1:0] a1, b1;
    logic [7:0]    op_r;
    logic [W4-1:0] m_r, p_r;
    assign dsp_P = p_r;

    // Slice registers share RST with the controller.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a1 <= '0; b1 <= '0; op_r <= '0; m_r <= '0; p_r <= '0;
        end else begin
            a1   <= dsp_A;
            b1   <= dsp_B;
            op_r <= dsp_OPMODE;
            m_r  <= W4'(a1) * W4'(b1);
            p_r  <= ((op_r[1:0] == 2'b01) ? m_r : '0) + ((op_r[3:2] == 2'b10) ? p_r : '0);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Offer one pair; returns at the negedge after the accepting edge.
    task automatic send(input logic [W2-1:0] a, input logic [W2-1:0] b);
        int n = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        while (!in_ready && n < 100) begin tick(); n++; end
        if (n >= 100) check("in_ready_timeout", in_ready, 1);
        tick();
        in_valid = 1'b0; in_a = '0; in_b = '0;
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        check("out_valid_timeout", out_valid, 1);
    endtask

    logic [7:0] trace [0:11];

    initial begin
        // Reset state
        @(negedge CLK);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_opmode", dsp_OPMODE, 8'h00);
        check("rst_out_data", out_data, 0);
        @(negedge CLK);
        RST = 1'b0;
        tick();

        // Basic sum with latency: 2+12+30+56 = 100
        out_ready = 1'b1;
        send(1, 2); send(3, 4); send(5, 6); send(7, 8);
        for (int k = 1; k <= PL; k++) begin
            tick();
            check("lat_not_yet", out_valid, 0);
        end
        tick();
        check("basic_valid", out_valid, 1);
        check("basic_data", out_data, 100);
        check("basic_sat", out_sat, 0);
        check("basic_in_ready", in_ready, 1);
        tick();
        check("basic_consumed", out_valid, 0);

        // Bubbles: taps on slots 0,3,6,9 with two idle slots between
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 10) && (i % 3 == 0);
            in_a = in_valid ? W2'(2 * (i / 3) + 1) : '0;
            in_b = in_valid ? W2'(2 * (i / 3) + 2) : '0;
            tick();
            trace[i] = dsp_OPMODE;
        end
        in_valid = 1'b0; in_a = '0; in_b = '0;
        begin
            int n09 = 0;
            for (int i = 2; i <= 10; i++) if (trace[i] == 8'h09) n09++;
            check("bub_op_first", trace[1], 8'h01);
            check("bub_op_acc_cnt", n09, 9);
            check("bub_op_hold", trace[11], 8'h08);
        end
        wait_out();
        check("bub_data", out_data, 100);
        tick();

        // Back-to-back results: 4 then 24
        for (int k = 0; k < 4; k++) send(1, 1);
        wait_out();
        check("b2b_first", out_data, 4);
        for (int k = 0; k < 4; k++) send(2, 3);
        wait_out();
        check("b2b_second", out_data, 24);
        tick();

        // Backpressure: two results with out_ready low
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(1, 1);
        for (int k = 0; k < 4; k++) send(2, 3);
        repeat (10) tick();
        check("bp_valid", out_valid, 1);
        check("bp_hold_data", out_data, 4);
        check("bp_in_ready", in_ready, 0);
        repeat (5) tick();
        check("bp_stable_data", out_data, 4);
        out_ready = 1'b1;
        tick();
        check("bp_replace_valid", out_valid, 1);
        check("bp_second_data", out_data, 24);
        check("bp_in_ready_back", in_ready, 1);
        tick();
        check("bp_drained", out_valid, 0);

        // Reset mid-accumulation
        send(5, 5); send(5, 5);
        RST = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_A", dsp_A, 0);
        check("mid_rst_B", dsp_B, 0);
        check("mid_rst_opmode", dsp_OPMODE, 8'h00);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_sat", out_sat, 0);
        @(negedge CLK);
        RST = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) send(1, 2);
        wait_out();
        check("post_rst_data", out_data, 8);
        tick();

        // Large operands: sum = 4*(2^18-1)^2 = 0x3F_FFE0_0004
        for (int k = 0; k < 4; k++) send(18'h3FFFF, 18'h3FFFF);
        wait_out();
`ifdef DSP_MAC_SAT_EN
        check("sat_data", out_data, 32'hFFFF_FFFF);
        check("sat_flag", out_sat, 1);
`else
        check("trunc_data", out_data, 32'hFFE0_0004);
        check("trunc_flag", out_sat, 0);
`endif
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
